// File: rtl/serial_tx_if.sv
// rtl/serial_tx_if.sv - parallel word handshake between producer and serial_tx
interface serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - framed bit-serial transmitter: start 0, DATA_W bits LSB-first, stop 1
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  serial_tx_if.slave  s_if,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_done
);
  localparam int DIV_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  state_t            r_state, w_state_nxt;
  logic [DIV_W-1:0]  r_div, w_div_nxt;
  logic [BIT_W-1:0]  r_bit, w_bit_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic              r_tx, w_tx_nxt;
  logic              r_done, w_done_nxt;
  logic              w_bit_end;
  logic [DATA_W-1:0] w_shifted;

  assign w_bit_end = (r_div == DIV_LAST);
  assign w_shifted = r_shift >> 1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // tx is registered, so each branch loads the level for the clock after the edge
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = w_bit_end ? '0 : r_div + DIV_W'(1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_div_nxt = '0;
        w_tx_nxt  = 1'b1;
        if (s_if.tx_valid) begin
          w_state_nxt = ST_START;
          w_shift_nxt = s_if.tx_data;
          w_bit_nxt   = '0;
          w_tx_nxt    = 1'b0;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt = ST_DATA;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = w_shifted;
          if (r_bit == BIT_LAST) begin
            w_state_nxt = ST_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt = r_bit + BIT_W'(1);
            w_tx_nxt  = w_shifted[0];
          end
        end
      end
      ST_STOP: begin
        if (r_div == DIV_PRE) w_done_nxt = 1'b1;
        if (w_bit_end) begin
          w_state_nxt = ST_IDLE;
          w_tx_nxt    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  assign s_if.tx_ready = (r_state == ST_IDLE);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_tx          = r_tx;
  assign o_done        = r_done;
endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - self-checking bench for serial_tx (default and minimum parameters)
module tb_serial_tx;
  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int L   = (DW + 2) * CPB;

  logic clk = 1'b0;
  logic reset;
  logic tx_a, busy_a, done_a;
  logic tx_b, busy_b, done_b;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_tx_if #(.DATA_W(DW)) if_a ();
  serial_tx_if #(.DATA_W(1))  if_b ();

  serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut_a (
    .i_clk(clk), .i_reset(reset), .s_if(if_a.slave),
    .o_tx(tx_a), .o_busy(busy_a), .o_done(done_a)
  );

  serial_tx #(.DATA_W(1), .CLKS_PER_BIT(2)) dut_b (
    .i_clk(clk), .i_reset(reset), .s_if(if_b.slave),
    .o_tx(tx_b), .o_busy(busy_b), .o_done(done_b)
  );

  typedef struct {
    logic [7:0] data;
    int         mode;   // 0 pulse, 1 hold valid, 2 random noise, 3 data change at E5
    logic [9:0] frame;  // bit i = expected tx level in bit slot i
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%0h expected=%0h", name, t, act, exp);
    end
  endtask

  // Reference: tx level at clock t after the accept edge, from slot arithmetic
  function automatic logic model_tx(input logic [7:0] w, input int t);
    int slot;
    slot = t / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= DW) return w[slot-1];
    return 1'b1;
  endfunction

  task automatic do_frame(input logic [7:0] word, input int mode, input logic [9:0] frame);
    chk("ready_pre", -1, 32'(if_a.tx_ready), 32'd1);
    if_a.tx_data  = word;
    if_a.tx_valid = 1'b1;
    tick();
    for (int t = 0; t <= L; t++) begin
      chk("tx",    t, 32'(tx_a),          32'((t == L) ? 1'b1 : frame[t / CPB]));
      chk("done",  t, 32'(done_a),        32'(t == L - 1));
      chk("ready", t, 32'(if_a.tx_ready), 32'(t == L));
      chk("busy",  t, 32'(busy_a),        32'(t < L));
      if (t < L) begin
        case (mode)
          0: if_a.tx_valid = 1'b0;
          1: if_a.tx_valid = 1'b1;
          2: begin
            if_a.tx_valid = 1'($urandom);
            if_a.tx_data  = 8'($urandom);
          end
          default: if (t == 4) begin
            if_a.tx_data  = 8'hC3;
            if_a.tx_valid = 1'b1;
          end
        endcase
        tick();
      end
    end
    if (mode != 1) if_a.tx_valid = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    logic [7:0] w;
    logic [9:0] fr;
    logic [5:0] exp_b;
    int         mode;
    int         gap;

    vecs[0] = '{8'hA5, 0, 10'b1101001010};
    vecs[1] = '{8'h00, 1, 10'b1000000000};
    vecs[2] = '{8'hFF, 0, 10'b1111111110};
    vecs[3] = '{8'h3C, 3, 10'b1001111000};
    vecs[4] = '{8'h01, 0, 10'b1000000010};
    vecs[5] = '{8'h80, 0, 10'b1100000000};

    reset = 1'b1;
    if_a.tx_valid = 1'b0;
    if_a.tx_data  = '0;
    if_b.tx_valid = 1'b0;
    if_b.tx_data  = '0;
    tick();
    tick();
    chk("rst_tx",    0, 32'(tx_a),          32'd1);
    chk("rst_busy",  0, 32'(busy_a),        32'd0);
    chk("rst_done",  0, 32'(done_a),        32'd0);
    chk("rst_ready", 0, 32'(if_a.tx_ready), 32'd1);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) do_frame(vecs[i].data, vecs[i].mode, vecs[i].frame);
    tick();

    // Reset mid-frame, sampled at E18 while in DATA
    chk("ready_pre", -1, 32'(if_a.tx_ready), 32'd1);
    if_a.tx_data  = 8'hA5;
    if_a.tx_valid = 1'b1;
    tick();
    if_a.tx_valid = 1'b0;
    for (int t = 1; t <= 17; t++) tick();
    chk("mid_busy", 17, 32'(busy_a), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_tx",    18, 32'(tx_a),          32'd1);
    chk("mid_ready", 18, 32'(if_a.tx_ready), 32'd1);
    chk("mid_busy",  18, 32'(busy_a),        32'd0);
    for (int k = 0; k < L + 4; k++) begin
      tick();
      chk("mid_nodone", k, 32'(done_a), 32'd0);
      chk("mid_idle",   k, 32'(tx_a),   32'd1);
    end
    do_frame(8'h5A, 0, 10'b1010110100);
    tick();

    // Reset and valid on the same edge: nothing accepted
    reset = 1'b1;
    if_a.tx_valid = 1'b1;
    if_a.tx_data  = 8'hFF;
    tick();
    chk("rv_ready", 0, 32'(if_a.tx_ready), 32'd1);
    chk("rv_busy",  0, 32'(busy_a),        32'd0);
    reset = 1'b0;
    if_a.tx_valid = 1'b0;
    tick();
    chk("rv_busy2", 1, 32'(busy_a), 32'd0);
    chk("rv_tx",    1, 32'(tx_a),   32'd1);

    // Randomised frames against the slot model
    for (int i = 0; i < 20; i++) begin
      w    = 8'($urandom);
      mode = $urandom_range(0, 2);
      for (int s = 0; s < 10; s++) fr[s] = model_tx(w, s * CPB);
      do_frame(w, mode, fr);
      if (mode != 1) begin
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          tick();
          chk("gap_tx",    g, 32'(tx_a),          32'd1);
          chk("gap_ready", g, 32'(if_a.tx_ready), 32'd1);
        end
      end
    end
    if_a.tx_valid = 1'b0;
    tick();
    tick();

    // Minimum parameters: DATA_W=1, CLKS_PER_BIT=2
    for (int v = 0; v < 2; v++) begin
      exp_b = (v == 0) ? 6'b111100 : 6'b110000;
      chk("b_ready_pre", -1, 32'(if_b.tx_ready), 32'd1);
      if_b.tx_data  = (v == 0) ? 1'b1 : 1'b0;
      if_b.tx_valid = 1'b1;
      tick();
      if_b.tx_valid = 1'b0;
      for (int t = 0; t <= 6; t++) begin
        chk("b_tx",    t, 32'(tx_b),          32'((t == 6) ? 1'b1 : exp_b[t]));
        chk("b_done",  t, 32'(done_b),        32'(t == 5));
        chk("b_ready", t, 32'(if_b.tx_ready), 32'(t == 6));
        chk("b_busy",  t, 32'(busy_b),        32'(t < 6));
        if (t < 6) tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
